// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core coherence bus: FSM states, request classes,
// default snoop hold time and the two-core tie-break helper.
package cpu_types_pkg;

  localparam int unsigned SNOOP_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    INV,
    WB,
    SNOOP,
    C2C,
    RAMRD,
    IFETCH
  } bus_state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_IREAD,
    CLS_DREAD,
    CLS_DWRITE,
    CLS_CCWRITE
  } req_class_t;

  // With both cores requesting, the one that did not win last time goes first.
  function automatic logic pick_core(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Fixed-priority class arbiter (ccwrite > dWEN > dREN > iREN) with a
// round-robin tie-break between the two cores inside a class.
module bus_rr_arbiter
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       grant_en,
  input  logic [1:0] ccwrite,
  input  logic [1:0] dWEN,
  input  logic [1:0] dREN,
  input  logic [1:0] iREN,
  output logic       gnt_valid,
  output logic       gnt_core,
  output req_class_t gnt_class
);

  logic last_grant_q, last_grant_d;

  // Pick the highest pending class, then the core within it.
  always_comb begin
    gnt_valid    = 1'b1;
    gnt_core     = 1'b0;
    gnt_class    = CLS_NONE;
    last_grant_d = last_grant_q;
    if (|ccwrite) begin
      gnt_class = CLS_CCWRITE;
      gnt_core  = pick_core(ccwrite, last_grant_q);
    end else if (|dWEN) begin
      gnt_class = CLS_DWRITE;
      gnt_core  = pick_core(dWEN, last_grant_q);
    end else if (|dREN) begin
      gnt_class = CLS_DREAD;
      gnt_core  = pick_core(dREN, last_grant_q);
    end else if (|iREN) begin
      gnt_class = CLS_IREAD;
      gnt_core  = pick_core(iREN, last_grant_q);
    end else begin
      gnt_valid = 1'b0;
    end
    if (grant_en && gnt_valid) begin
      last_grant_d = gnt_core;
    end
  end

  // Remember which core won the most recent grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Dual-core memory/coherence controller: one RAM port shared by two icaches
// and two dcaches, with MSI snooping between the dcaches. All outputs are
// decoded from registered state so reset drops every strobe at once.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS         = 2,
  parameter int unsigned SNOOP_CYCLES = SNOOP_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       ccwrite,
  input  logic [1:0]       cctrans,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ram_ready
);

  localparam int unsigned CORE_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned CNT_W  = $clog2(SNOOP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_CYCLES - 1);

  bus_state_t        state_q, state_d;
  logic [CORE_W-1:0] core_q, core_d;
  logic [CORE_W-1:0] oth;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;

  logic       gnt_valid;
  logic       gnt_core;
  req_class_t gnt_class;
  logic       req_held;

  bus_rr_arbiter u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .grant_en  (state_q == IDLE),
    .ccwrite   (ccwrite),
    .dWEN      (dWEN),
    .dREN      (dREN),
    .iREN      (iREN),
    .gnt_valid (gnt_valid),
    .gnt_core  (gnt_core),
    .gnt_class (gnt_class)
  );

  assign oth = ~core_q;

  // Next-state and output decode for the single in-flight transaction.
  always_comb begin
    state_d     = state_q;
    core_d      = core_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          core_d = gnt_core;
          cnt_d  = '0;
          case (gnt_class)
            CLS_CCWRITE: state_d = INV;
            CLS_DWRITE:  state_d = WB;
            CLS_DREAD:   state_d = SNOOP;
            CLS_IREAD:   state_d = IFETCH;
            default:     state_d = IDLE;
          endcase
        end
      end
      INV: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = 1'b1;
        ccsnoopaddr[oth] = daddr[core_q];
        ccinv[core_q]    = 1'b1;
        state_d          = IDLE;
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[core_q];
        ramstore = dstore[core_q];
        if (ram_ready) begin
          dwait[core_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      SNOOP: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = daddr[core_q];
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cctrans[oth]) begin
            data_d  = dstore[oth];
            state_d = C2C;
          end else begin
            state_d = RAMRD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      C2C: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = daddr[core_q];
        ramWEN           = 1'b1;
        ramaddr          = daddr[core_q];
        ramstore         = data_q;
        if (ram_ready) begin
          dload[core_q] = data_q;
          dwait[core_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[core_q];
        if (ram_ready) begin
          dload[core_q] = ramload;
          dwait[core_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[core_q];
        if (ram_ready) begin
          iload[core_q] = ramload;
          iwait[core_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, granted core, snoop counter and latched snoop word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      core_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // The strobe that started the current transaction must stay up until it ends.
  always_comb begin
    req_held = 1'b1;
    case (state_q)
      INV:               req_held = ccwrite[core_q];
      WB:                req_held = dWEN[core_q];
      SNOOP, C2C, RAMRD: req_held = dREN[core_q];
      IFETCH:            req_held = iREN[core_q];
      default:           req_held = 1'b1;
    endcase
  end

  a_req_held : assert property (@(posedge CLK) disable iff (!nRST) req_held);

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with a RAM model and an ordered
// completion scoreboard.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       ccwrite;
  logic [1:0]       cctrans;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic             ram_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ram_lat = 3;
  int unsigned lat_cnt = 0;
  int unsigned ren_cycles = 0;

  logic [31:0] mem [logic [31:0]];

  // Completion codes: 0/1 = dcache core, 2/3 = icache core.
  typedef struct {
    int unsigned code;
    bit          chk_data;
    logic [31:0] data;
  } sb_t;
  sb_t sb [$];

  coherence_bus_ctrl #(.CPUS(2), .SNOOP_CYCLES(2)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .ccwrite     (ccwrite),
    .cctrans     (cctrans),
    .dwait       (dwait),
    .dload       (dload),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ram_ready   (ram_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned code, input bit chk_data, input logic [31:0] data);
    sb_t e;
    e.code     = code;
    e.chk_data = chk_data;
    e.data     = data;
    sb.push_back(e);
  endtask

  // Drop each requester's strobe the cycle after its completion is seen.
  task automatic run_until_done(input string tag);
    logic [1:0] clr_d;
    logic [1:0] clr_i;
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (dREN == 2'b00 && dWEN == 2'b00 && iREN == 2'b00) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
      clr_d = ~dwait;
      clr_i = ~iwait;
      @(posedge CLK); #1;
      dREN = dREN & ~clr_d;
      dWEN = dWEN & ~clr_d;
      iREN = iREN & ~clr_i;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge CLK);
    chk({tag, "_iwait_hi"}, 32'(iwait), 32'd3);
    chk({tag, "_dwait_hi"}, 32'(dwait), 32'd3);
  endtask

  // RAM model: completes an access ram_lat cycles after its strobe appears.
  initial begin
    ram_ready = 1'b0;
    ramload   = '0;
    forever begin
      @(posedge CLK); #1;
      if (!nRST) begin
        ram_ready = 1'b0;
        lat_cnt   = 0;
      end else if (ram_ready) begin
        ram_ready = 1'b0;
        ramload   = '0;
        lat_cnt   = 0;
      end else if (ramREN || ramWEN) begin
        lat_cnt++;
        if (lat_cnt >= ram_lat) begin
          ram_ready = 1'b1;
          if (ramREN) ramload = mem.exists(ramaddr) ? mem[ramaddr] : 32'h0;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Bus monitor: strobe exclusivity, RAM writes, scoreboard on completions.
  always @(negedge CLK) begin : monitor
    sb_t e;
    logic done_now;
    logic [31:0] got;
    if (nRST) begin
      chk("one_strobe", 32'(ramREN & ramWEN), 32'd0);
      if (ramREN) ren_cycles++;
      if (ram_ready && ramWEN) mem[ramaddr] = ramstore;
      for (int c = 0; c < 4; c++) begin
        done_now = (c < 2) ? (dwait[c[0]] === 1'b0) : (iwait[c[0]] === 1'b0);
        got      = (c < 2) ? dload[c[0]] : iload[c[0]];
        if (done_now) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("completion_port", 32'(c), e.code);
            if (e.chk_data) chk("completion_data", got, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int unsigned ren_snap;
    nRST    = 1'b0;
    iREN    = '0;
    iaddr   = '0;
    dREN    = '0;
    dWEN    = '0;
    daddr   = '0;
    dstore  = '0;
    ccwrite = '0;
    cctrans = '0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h208] = 32'hCAFE0208;
    mem[32'h300] = 32'h0000_3300;
    mem[32'h304] = 32'h0000_3304;
    mem[32'h400] = 32'h1357_9BDF;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 32'd3);
    chk("rst_dwait", 32'(dwait), 32'd3);
    chk("rst_ccwait", 32'(ccwait), 32'd0);
    chk("rst_ccinv", 32'(ccinv), 32'd0);
    chk("rst_ramstrobe", 32'({ramREN, ramWEN}), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload[0] | iload[1], 32'd0);
    chk("rst_dload", dload[0] | dload[1], 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("idle_dwait", 32'(dwait), 32'd3);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Instruction fetch, core 0
    @(posedge CLK); #1;
    ram_lat  = 3;
    iREN[0]  = 1'b1;
    iaddr[0] = 32'h100;
    push_exp(2, 1'b1, 32'hDEADBEEF);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ramREN === 1'b1) begin ok = 1'b1; break; end
    end
    chk("fetch_ren_seen", 32'(ok), 32'd1);
    chk("fetch_ramaddr", ramaddr, 32'h100);
    chk("fetch_no_wen", 32'(ramWEN), 32'd0);
    run_until_done("fetch");

    // Clean snoop: core 1 reads, core 0 has no dirty copy
    @(posedge CLK); #1;
    dREN[1]  = 1'b1;
    daddr[1] = 32'h208;
    push_exp(1, 1'b1, 32'hCAFE0208);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ccwait[0] === 1'b1) begin ok = 1'b1; break; end
    end
    chk("csnoop_ccwait_seen", 32'(ok), 32'd1);
    chk("csnoop_addr_c1", ccsnoopaddr[0], 32'h208);
    chk("csnoop_no_ren_c1", 32'(ramREN), 32'd0);
    @(negedge CLK);
    chk("csnoop_ccwait_c2", 32'(ccwait), 32'd1);
    chk("csnoop_addr_c2", ccsnoopaddr[0], 32'h208);
    @(negedge CLK);
    chk("csnoop_ccwait_off", 32'(ccwait), 32'd0);
    chk("csnoop_ren", 32'(ramREN), 32'd1);
    chk("csnoop_ramaddr", ramaddr, 32'h208);
    run_until_done("csnoop");

    // Dirty snoop: core 0 reads, core 1 supplies the word
    @(posedge CLK); #1;
    ren_snap  = ren_cycles;
    dREN[0]   = 1'b1;
    daddr[0]  = 32'h40;
    cctrans[1] = 1'b1;
    dstore[1] = 32'h1234;
    push_exp(0, 1'b1, 32'h1234);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ramWEN === 1'b1) begin ok = 1'b1; break; end
    end
    chk("dsnoop_wen_seen", 32'(ok), 32'd1);
    chk("dsnoop_ramaddr", ramaddr, 32'h40);
    chk("dsnoop_ramstore", ramstore, 32'h1234);
    chk("dsnoop_ccwait_held", 32'(ccwait), 32'd2);
    run_until_done("dsnoop");
    cctrans = '0;
    dstore  = '0;
    chk("dsnoop_writethrough", mem.exists(32'h40) ? mem[32'h40] : 32'h0, 32'h1234);
    chk("dsnoop_no_ren", ren_cycles, ren_snap);

    // Invalidate from core 0
    @(posedge CLK); #1;
    ccwrite[0] = 1'b1;
    daddr[0]   = 32'h80;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ccinv !== 2'b00) begin ok = 1'b1; break; end
    end
    chk("inv_seen", 32'(ok), 32'd1);
    chk("inv_ccinv", 32'(ccinv), 32'd3);
    chk("inv_ccwait", 32'(ccwait), 32'd2);
    chk("inv_snoopaddr", ccsnoopaddr[1], 32'h80);
    chk("inv_no_ram", 32'({ramREN, ramWEN}), 32'd0);
    @(posedge CLK); #1;
    ccwrite = '0;
    @(negedge CLK);
    chk("inv_one_cycle", 32'({ccinv, ccwait}), 32'd0);

    // Contention: dREN on both cores plus iREN[0], last grant was core 0
    @(posedge CLK); #1;
    ram_lat  = 1;
    dREN     = 2'b11;
    daddr[0] = 32'h300;
    daddr[1] = 32'h304;
    iREN[0]  = 1'b1;
    iaddr[0] = 32'h400;
    push_exp(1, 1'b1, 32'h0000_3304);
    push_exp(0, 1'b1, 32'h0000_3300);
    push_exp(2, 1'b1, 32'h1357_9BDF);
    run_until_done("contend");

    // Writeback from core 1
    @(posedge CLK); #1;
    ram_lat   = 2;
    dWEN[1]   = 1'b1;
    daddr[1]  = 32'h600;
    dstore[1] = 32'h0000_0077;
    push_exp(1, 1'b0, 32'h0);
    run_until_done("wb");
    chk("wb_mem", mem.exists(32'h600) ? mem[32'h600] : 32'h0, 32'h0000_0077);

    // Reset in the middle of a writeback
    @(posedge CLK); #1;
    ram_lat   = 6;
    dWEN[1]   = 1'b1;
    daddr[1]  = 32'h500;
    dstore[1] = 32'hA5A5_A5A5;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ramWEN === 1'b1) begin ok = 1'b1; break; end
    end
    chk("rstwb_wen_seen", 32'(ok), 32'd1);
    chk("rstwb_ramaddr", ramaddr, 32'h500);
    #2;
    nRST = 1'b0;
    #1;
    chk("rstwb_wen_drop", 32'(ramWEN), 32'd0);
    chk("rstwb_ren_off", 32'(ramREN), 32'd0);
    chk("rstwb_dwait", 32'(dwait), 32'd3);
    dWEN   = '0;
    dstore = '0;
    @(negedge CLK); #2;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rstwb_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstwb_dwait_after", 32'(dwait), 32'd3);
    chk("rstwb_wen_after", 32'(ramWEN), 32'd0);

    // Simultaneous ccwrite; last grant reset to 0 so core 1 goes first
    @(posedge CLK); #1;
    ccwrite  = 2'b11;
    daddr[0] = 32'h900;
    daddr[1] = 32'h904;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ccinv !== 2'b00) begin ok = 1'b1; break; end
    end
    chk("dual_inv_seen", 32'(ok), 32'd1);
    chk("dual_first_ccwait", 32'(ccwait), 32'd1);
    chk("dual_first_addr", ccsnoopaddr[0], 32'h904);
    @(posedge CLK); #1;
    ccwrite[1] = 1'b0;
    @(negedge CLK);
    chk("dual_bubble", 32'(ccinv), 32'd0);
    @(negedge CLK);
    chk("dual_second_ccwait", 32'(ccwait), 32'd2);
    chk("dual_second_ccinv", 32'(ccinv), 32'd3);
    chk("dual_second_addr", ccsnoopaddr[1], 32'h900);
    @(posedge CLK); #1;
    ccwrite = '0;
    @(negedge CLK);
    chk("dual_done", 32'(ccinv), 32'd0);

    repeat (2) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
